// File: rtl/gf251_addsub_vec_if.sv
// Valid/ready stream bundle for the GF(251) vector add/sub unit.
// The master side drives operands and output ready; the slave is the unit.
interface gf251_addsub_vec_if #(
    parameter int LANES = 4
);
    localparam int W = 8 * LANES;

    logic         i_valid;
    logic         o_ready;
    logic [1:0]   i_mode;
    logic [W-1:0] i_x;
    logic [W-1:0] i_y;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_o;

    modport master (
        output i_valid,
        output i_mode,
        output i_x,
        output i_y,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_o
    );

    modport slave (
        input  i_valid,
        input  i_mode,
        input  i_x,
        input  i_y,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_o
    );
endinterface

// File: rtl/gf251_addsub_vec.sv
// Two-stage GF(251) vector unit: add, sub, accumulate, accumulate-and-flush.
// S1 computes and reduces; S2 is the output register with full backpressure.
module gf251_addsub_vec #(
    parameter int LANES = 4
) (
    input logic                i_clk,
    input logic                i_rst,
    gf251_addsub_vec_if.slave  bus
);
    localparam int W = 8 * LANES;

    localparam logic [1:0] MODE_ADD   = 2'd0;
    localparam logic [1:0] MODE_SUB   = 2'd1;
    localparam logic [1:0] MODE_ACC   = 2'd2;
    localparam logic [1:0] MODE_FLUSH = 2'd3;

    logic         s1_valid;
    logic [W-1:0] s1_data;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [W-1:0] acc;

    logic         s1_adv;
    logic         in_xfer;
    logic [W-1:0] result;
    logic [W-1:0] acc_next;

    function automatic logic [7:0] norm(input logic [7:0] v);
        return (v >= 8'd251) ? (v - 8'd251) : v;
    endfunction

    function automatic logic [7:0] add_mod(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 9'd251) begin
            s = s - 9'd251;
        end
        return s[7:0];
    endfunction

    // Operands are already canonical, so a+251-b stays within 9 bits.
    function automatic logic [7:0] sub_mod(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [8:0] d;
        if (a >= b) begin
            d = {1'b0, a} - {1'b0, b};
        end else begin
            d = {1'b0, a} + 9'd251 - {1'b0, b};
        end
        return d[7:0];
    endfunction

    assign s1_adv      = !out_valid || bus.i_ready;
    assign bus.o_ready = !s1_valid || s1_adv;
    assign in_xfer     = bus.i_valid && bus.o_ready;
    assign bus.o_valid = out_valid;
    assign bus.o_o     = out_data;

    always_comb begin
        logic [7:0] xn;
        logic [7:0] yn;
        logic [7:0] r;
        result   = '0;
        acc_next = acc;
        for (int k = 0; k < LANES; k++) begin
            xn = norm(bus.i_x[8*k +: 8]);
            yn = norm(bus.i_y[8*k +: 8]);
            r  = 8'd0;
            unique case (bus.i_mode)
                MODE_ADD: begin
                    r = add_mod(xn, yn);
                end
                MODE_SUB: begin
                    r = sub_mod(xn, yn);
                end
                MODE_ACC: begin
                    r = add_mod(acc[8*k +: 8], xn);
                    acc_next[8*k +: 8] = r;
                end
                MODE_FLUSH: begin
                    r = add_mod(acc[8*k +: 8], xn);
                    acc_next[8*k +: 8] = 8'd0;
                end
            endcase
            result[8*k +: 8] = r;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc <= '0;
        end else if (in_xfer) begin
            acc <= acc_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_data  <= result;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Output data keeps its last value when S1 is empty on an advance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (s1_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= s1_data;
            end
        end
    end
endmodule

// File: tb/tb_gf251_addsub_vec.sv
// Scoreboard bench for gf251_addsub_vec: directed vectors on a 4-lane
// and an 8-lane instance, backpressure and mid-stream reset.
module tb_gf251_addsub_vec;
    logic clk;
    logic rst;

    gf251_addsub_vec_if #(.LANES(4)) bus4();
    gf251_addsub_vec_if #(.LANES(8)) bus8();

    gf251_addsub_vec #(.LANES(4)) dut4 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus4)
    );

    gf251_addsub_vec #(.LANES(8)) dut8 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] q4[$];
    logic [63:0] q8[$];

    int          occ = 0;
    logic        have_prev = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_o = '0;
    logic        bp_en = 1'b0;
    logic [15:0] bp_pat = 16'b1011_0011_1000_1101;
    int          bp_idx = 0;

    always @(negedge clk) begin
        if (bp_en) begin
            bus4.i_ready = bp_pat[bp_idx % 16];
            bp_idx++;
        end
    end

    // Monitor for the 4-lane unit, sampled well after the falling edge.
    always @(negedge clk) begin
        logic        exp_rdy;
        logic [31:0] e;
        #2;
        if (rst) begin
            occ = 0;
            have_prev = 1'b0;
        end else begin
            if (have_prev && prev_stall) begin
                checks++;
                if (bus4.o_valid !== 1'b1 || bus4.o_o !== prev_o) begin
                    errors++;
                    $display("FAIL hold4 got v=%0b o=%h want v=1 o=%h",
                             bus4.o_valid, bus4.o_o, prev_o);
                end
            end
            exp_rdy = !(occ == 2 && !bus4.i_ready);
            checks++;
            if (bus4.o_ready !== exp_rdy) begin
                errors++;
                $display("FAIL ready4 got %0b want %0b (occ=%0d)",
                         bus4.o_ready, exp_rdy, occ);
            end
            if (bus4.o_valid && bus4.i_ready) begin
                checks++;
                if (q4.size() == 0) begin
                    errors++;
                    $display("FAIL out4 got %h want nothing", bus4.o_o);
                end else begin
                    e = q4.pop_front();
                    if (bus4.o_o !== e) begin
                        errors++;
                        $display("FAIL out4 got %h want %h", bus4.o_o, e);
                    end
                end
            end
            occ = occ + ((bus4.i_valid && bus4.o_ready) ? 1 : 0)
                      - ((bus4.o_valid && bus4.i_ready) ? 1 : 0);
            prev_stall = bus4.o_valid && !bus4.i_ready;
            prev_o = bus4.o_o;
            have_prev = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [63:0] e;
        #2;
        if (!rst && bus8.o_valid && bus8.i_ready) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL out8 got %h want nothing", bus8.o_o);
            end else begin
                e = q8.pop_front();
                if (bus8.o_o !== e) begin
                    errors++;
                    $display("FAIL out8 got %h want %h", bus8.o_o, e);
                end
            end
        end
    end

    task automatic send4(input logic [1:0] m, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp);
        int n = 0;
        bus4.i_valid = 1'b1;
        bus4.i_mode = m;
        bus4.i_x = x;
        bus4.i_y = y;
        #1;
        while (!bus4.o_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept4 got o_ready=0 want 1 within 100 cycles");
        end else begin
            q4.push_back(exp);
        end
        @(negedge clk);
        bus4.i_valid = 1'b0;
    endtask

    task automatic send8(input logic [1:0] m, input logic [63:0] x,
                         input logic [63:0] y, input logic [63:0] exp);
        int n = 0;
        bus8.i_valid = 1'b1;
        bus8.i_mode = m;
        bus8.i_x = x;
        bus8.i_y = y;
        #1;
        while (!bus8.o_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept8 got o_ready=0 want 1 within 100 cycles");
        end else begin
            q8.push_back(exp);
        end
        @(negedge clk);
        bus8.i_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((q4.size() != 0 || q8.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q4.size() != 0 || q8.size() != 0) begin
            errors++;
            $display("FAIL drain_%s got %0d pending want 0", tag,
                     q4.size() + q8.size());
        end
    endtask

    task automatic expect_idle(input string tag);
        checks++;
        if (bus4.o_valid !== 1'b0 || bus4.o_o !== 32'h0 ||
            bus4.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s got v=%0b o=%h r=%0b want v=0 o=0 r=1", tag,
                     bus4.o_valid, bus4.o_o, bus4.o_ready);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus4.i_valid = 1'b0;
        bus4.i_mode = 2'd0;
        bus4.i_x = '0;
        bus4.i_y = '0;
        bus4.i_ready = 1'b1;
        bus8.i_valid = 1'b0;
        bus8.i_mode = 2'd0;
        bus8.i_x = '0;
        bus8.i_y = '0;
        bus8.i_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        expect_idle("reset");
        @(negedge clk);

        send4(2'd0, 32'h22222222, 32'h44444444, 32'h66666666);
        send4(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h08080808);
        send4(2'd0, 32'h12345678, 32'h87654321, 32'h99999999);
        drain("add");

        send4(2'd1, 32'h22222222, 32'h44444444, 32'hD9D9D9D9);
        send4(2'd1, 32'h000000FB, 32'h00000001, 32'h000000FA);
        drain("sub");

        send4(2'd2, 32'h7D7D7D7D, 32'hDEADBEEF, 32'h7D7D7D7D);
        send4(2'd2, 32'h7D7D7D7D, 32'h12345678, 32'hFAFAFAFA);
        send4(2'd0, 32'h01020304, 32'h01010101, 32'h02030405);
        send4(2'd2, 32'h7D7D7D7D, 32'h00000000, 32'h7C7C7C7C);
        send4(2'd3, 32'h00000000, 32'hFFFFFFFF, 32'h7C7C7C7C);
        send4(2'd2, 32'h01010101, 32'h00000000, 32'h01010101);
        send4(2'd3, 32'h00000000, 32'h00000000, 32'h01010101);
        drain("acc");

        bp_en = 1'b1;
        send4(2'd0, 32'h01010101, 32'hF5F5F5F5, 32'hF6F6F6F6);
        send4(2'd0, 32'h02020202, 32'hF5F5F5F5, 32'hF7F7F7F7);
        send4(2'd0, 32'h03030303, 32'hF5F5F5F5, 32'hF8F8F8F8);
        send4(2'd0, 32'h04040404, 32'hF5F5F5F5, 32'hF9F9F9F9);
        send4(2'd0, 32'h05050505, 32'hF5F5F5F5, 32'hFAFAFAFA);
        send4(2'd0, 32'h06060606, 32'hF5F5F5F5, 32'h00000000);
        drain("bp");
        bp_en = 1'b0;
        @(negedge clk);
        bus4.i_ready = 1'b1;

        bus4.i_ready = 1'b0;
        send4(2'd2, 32'h03030303, 32'h0, 32'h03030303);
        send4(2'd2, 32'h04040404, 32'h0, 32'h07070707);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        q4.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        expect_idle("midreset");
        @(negedge clk);
        bus4.i_ready = 1'b1;
        send4(2'd2, 32'h05050505, 32'h0, 32'h05050505);
        drain("postreset");

        send8(2'd0, 64'hFAFAFAFAFAFAFAFA, 64'h0101010101010101,
              64'h0000000000000000);
        send8(2'd0, 64'hFAFAFAFAFAFAFAFA, 64'hFAFAFAFAFAFAFAFA,
              64'hF9F9F9F9F9F9F9F9);
        send8(2'd1, 64'h0001020304050607, 64'h0101010101010101,
              64'hFA00010203040506);
        drain("lanes8");

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
